counter_adder_unit: RTL and testbench
=====================================

COUNTER_ADDER_UNIT -- requirements
Module: counter_adder_unit

Interface
REQ-001 Parameter WIDTH, 5: counter and leds width in bits.
REQ-002 Parameter PRESCALE, 1: enabled clock cycles per counter increment; legal range 1 to 2^16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 en  input  1  count enable; counter and prescaler hold when low.
REQ-006 leds  output  WIDTH  registered counter value.
REQ-007 wrap  output  1  registered one-cycle pulse when leds wraps from all-ones to zero.
REQ-008 ha_data_0  input  1  half-adder operand A.
REQ-009 ha_data_1  input  1  half-adder operand B.
REQ-010 ha_out  output  1  half-adder sum.
REQ-011 ha_carry_out  output  1  half-adder carry.
REQ-012 fa_carry_in  input  1  full-adder carry input.
REQ-013 fa_data_0  input  1  full-adder operand A.
REQ-014 fa_data_1  input  1  full-adder operand B.
REQ-015 fa_out  output  1  full-adder sum.
REQ-016 fa_carry_out  output  1  full-adder carry.

Function
REQ-017 ha_out SHALL equal ha_data_0 XOR ha_data_1.
REQ-018 ha_carry_out SHALL equal ha_data_0 AND ha_data_1.
REQ-019 fa_out SHALL equal fa_data_0 XOR fa_data_1 XOR fa_carry_in.
REQ-020 fa_carry_out SHALL equal the majority function of fa_data_0, fa_data_1 and fa_carry_in.
REQ-021 Both adders SHALL be purely combinational, with zero cycle latency, and independent of clk, rst_n and en.
REQ-022 The full adder SHALL be built from two half-adder instances plus an OR of their carries.
REQ-023 The counter increment SHALL be computed by a WIDTH-stage ripple chain of half adders with carry-in 1; no behavioural "+" is used for leds.
REQ-024 A prescale counter SHALL count enabled cycles from 0 to PRESCALE-1.
REQ-025 The increment SHALL occur on the enabled cycle where the prescale counter equals PRESCALE-1, and the prescale counter SHALL return to 0 on that cycle.
REQ-026 With PRESCALE=1, leds SHALL increment on every enabled rising edge, one cycle after en is sampled high.
REQ-027 When en is low, leds, the prescale counter and wrap SHALL hold, except that wrap SHALL be driven 0.
REQ-028 Wrap-around: an increment from 2^WIDTH-1 SHALL produce leds=0 and assert wrap for exactly that one cycle.
REQ-029 wrap SHALL be 0 on every cycle with no wrapping increment.

Reset
REQ-030 When rst_n is sampled low at a rising edge, leds SHALL become 0, the prescale counter SHALL become 0 and wrap SHALL become 0.
REQ-031 Reset SHALL take priority over en, including mid-prescale and on a wrapping cycle.
REQ-032 Adder outputs SHALL be unaffected by reset.
REQ-033 After rst_n rises with en high, the first increment SHALL occur PRESCALE enabled edges later.

Verification
REQ-034 Half adder, inputs 00/01/10/11 -> (ha_out, ha_carry_out) = 00/10/10/01.
REQ-035 Full adder, all 8 input combinations; in particular 0,0,0 -> 0 0 and 1,1,1 -> 1 1, and 1,1,0 -> out 0, carry 1.
REQ-036 PRESCALE=1, rst_n low for 2 edges, then en=1 for 33 edges -> leds sequence 0,1,...,31,0,1; wrap high only in the cycle leds=0 after 31.
REQ-037 PRESCALE=3, en=1 -> leds steps every third edge: 0,0,1,1,1,2...
REQ-038 En low for 5 edges at leds=7 -> leds stays 7 and wrap stays 0; counting resumes from 7.
REQ-039 rst_n low at leds=19 with en=1 -> next edge leds=0; adder outputs unchanged throughout.

Source files
------------

// File: rtl/counter_adder_unit.sv
// rtl/counter_adder_unit.sv - prescaled free-running counter with wrap pulse, plus standalone half/full adders.

module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);
   assign sum   = a ^ b;
   assign carry = a & b;
endmodule

module full_adder (
   input  logic a,
   input  logic b,
   input  logic carry_in,
   output logic sum,
   output logic carry_out
);
   logic s0;
   logic c0;
   logic c1;

   half_adder u_ha0 (.a(a),  .b(b),        .sum(s0),  .carry(c0));
   half_adder u_ha1 (.a(s0), .b(carry_in), .sum(sum), .carry(c1));

   assign carry_out = c0 | c1;
endmodule

module counter_adder_unit #(
   parameter int WIDTH    = 5,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [WIDTH-1:0] leds,
   output logic             wrap,
   input  logic             ha_data_0,
   input  logic             ha_data_1,
   output logic             ha_out,
   output logic             ha_carry_out,
   input  logic             fa_carry_in,
   input  logic             fa_data_0,
   input  logic             fa_data_1,
   output logic             fa_out,
   output logic             fa_carry_out
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0]    pre;
   logic [WIDTH-1:0] inc;
   logic [WIDTH:0]   chain;
   logic             tick;

   half_adder u_ha (
      .a(ha_data_0), .b(ha_data_1), .sum(ha_out), .carry(ha_carry_out)
   );

   full_adder u_fa (
      .a(fa_data_0), .b(fa_data_1), .carry_in(fa_carry_in),
      .sum(fa_out), .carry_out(fa_carry_out)
   );

   // Ripple incrementer; carry out of the top stage marks the all-ones wrap.
   assign chain[0] = 1'b1;
   for (genvar i = 0; i < WIDTH; i++) begin : g_inc
      half_adder u_stage (
         .a(leds[i]), .b(chain[i]), .sum(inc[i]), .carry(chain[i+1])
      );
   end

   assign tick = (pre == PW'(PRESCALE - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         leds <= '0;
         pre  <= '0;
         wrap <= 1'b0;
      end else if (en) begin
         if (tick) begin
            leds <= inc;
            pre  <= '0;
            wrap <= chain[WIDTH];
         end else begin
            pre  <= pre + PW'(1);
            wrap <= 1'b0;
         end
      end else begin
         wrap <= 1'b0;
      end
   end
endmodule

// File: tb/tb_counter_adder_unit.sv
// tb/tb_counter_adder_unit.sv - scoreboard bench for counter_adder_unit at PRESCALE 1 and 3.

module tb_counter_adder_unit;
   logic       clk = 1'b0;
   logic       rst_n, en, rst3_n, en3;
   logic       ha_a, ha_b, fa_a, fa_b, fa_c;
   logic [4:0] leds, leds3;
   logic       wrap, wrap3;
   logic       ha_s, ha_c, fa_s, fa_co;
   logic       ha_s3, ha_c3, fa_s3, fa_co3;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [4:0] l;
      logic       w;
      logic [4:0] l3;
      logic       w3;
   } exp_t;
   exp_t sb[$];

   logic [4:0] m_cnt = '0;
   logic       m_w = 1'b0;
   logic [4:0] m3_cnt = '0;
   logic       m3_w = 1'b0;
   int         m3_pre = 0;

   always #5 clk = ~clk;

   counter_adder_unit #(.WIDTH(5), .PRESCALE(1)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .leds(leds), .wrap(wrap),
      .ha_data_0(ha_a), .ha_data_1(ha_b), .ha_out(ha_s), .ha_carry_out(ha_c),
      .fa_carry_in(fa_c), .fa_data_0(fa_a), .fa_data_1(fa_b),
      .fa_out(fa_s), .fa_carry_out(fa_co)
   );

   counter_adder_unit #(.WIDTH(5), .PRESCALE(3)) dut3 (
      .clk(clk), .rst_n(rst3_n), .en(en3), .leds(leds3), .wrap(wrap3),
      .ha_data_0(ha_a), .ha_data_1(ha_b), .ha_out(ha_s3), .ha_carry_out(ha_c3),
      .fa_carry_in(fa_c), .fa_data_0(fa_a), .fa_data_1(fa_b),
      .fa_out(fa_s3), .fa_carry_out(fa_co3)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_adders();
      logic [1:0] ha_tab [4];
      logic [1:0] idx;
      int         s;
      ha_tab = '{2'b00, 2'b10, 2'b10, 2'b01};
      idx = {ha_a, ha_b};
      s = int'(fa_a) + int'(fa_b) + int'(fa_c);
      chk("ha",  {6'd0, ha_s,  ha_c},  {6'd0, ha_tab[idx]});
      chk("ha3", {6'd0, ha_s3, ha_c3}, {6'd0, ha_tab[idx]});
      chk("fa",  {6'd0, fa_s,  fa_co},  {6'd0, s[0], s >= 2});
      chk("fa3", {6'd0, fa_s3, fa_co3}, {6'd0, s[0], s >= 2});
   endtask

   task automatic step();
      exp_t e;
      if (!rst_n) begin
         m_cnt = '0; m_w = 1'b0;
      end else if (en) begin
         m_w = (m_cnt == 5'd31);
         m_cnt = m_cnt + 5'd1;
      end else begin
         m_w = 1'b0;
      end
      if (!rst3_n) begin
         m3_cnt = '0; m3_pre = 0; m3_w = 1'b0;
      end else if (en3) begin
         if (m3_pre == 2) begin
            m3_w = (m3_cnt == 5'd31);
            m3_cnt = m3_cnt + 5'd1;
            m3_pre = 0;
         end else begin
            m3_pre++;
            m3_w = 1'b0;
         end
      end else begin
         m3_w = 1'b0;
      end
      e = '{m_cnt, m_w, m3_cnt, m3_w};
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("leds",  {3'd0, leds},  {3'd0, e.l});
      chk("wrap",  {7'd0, wrap},  {7'd0, e.w});
      chk("leds3", {3'd0, leds3}, {3'd0, e.l3});
      chk("wrap3", {7'd0, wrap3}, {7'd0, e.w3});
      chk_adders();
   endtask

   initial begin
      rst_n = 1'b0; rst3_n = 1'b0; en = 1'b0; en3 = 1'b0;
      ha_a = 1'b0; ha_b = 1'b0; fa_a = 1'b0; fa_b = 1'b0; fa_c = 1'b0;
      repeat (2) step();
      chk("reset_leds", {3'd0, leds}, 8'd0);
      chk("reset_wrap", {7'd0, wrap}, 8'd0);

      for (int i = 0; i < 4; i++) begin
         {ha_a, ha_b} = 2'(i);
         #1;
         chk_adders();
      end
      for (int i = 0; i < 8; i++) begin
         {fa_a, fa_b, fa_c} = 3'(i);
         #1;
         chk_adders();
      end
      fa_a = 1'b1; fa_b = 1'b1; fa_c = 1'b0;
      #1;
      chk("fa_110", {6'd0, fa_s, fa_co}, 8'b01);

      rst_n = 1'b1; rst3_n = 1'b1; en = 1'b1; en3 = 1'b1;
      repeat (33) step();
      chk("after_33", {3'd0, leds}, 8'd1);
      repeat (6) step();
      chk("at_7", {3'd0, leds}, 8'd7);

      en = 1'b0; en3 = 1'b0;
      repeat (5) step();
      en = 1'b1; en3 = 1'b1;
      step();
      chk("resume_8", {3'd0, leds}, 8'd8);

      rst3_n = 1'b0;
      step();
      rst3_n = 1'b1;
      repeat (3) step();
      chk("p3_first_inc", {3'd0, leds3}, 8'd1);

      repeat (7) step();
      chk("at_19", {3'd0, leds}, 8'd19);
      ha_a = 1'b1; ha_b = 1'b1; fa_a = 1'b1; fa_b = 1'b0; fa_c = 1'b1;
      rst_n = 1'b0;
      step();
      chk("rst_at_19", {3'd0, leds}, 8'd0);
      rst_n = 1'b1;
      repeat (31) step();
      chk("at_31", {3'd0, leds}, 8'd31);
      rst_n = 1'b0;
      step();
      chk("rst_on_wrap_wrap", {7'd0, wrap}, 8'd0);
      rst_n = 1'b1;
      step();
      chk("post_rst_1", {3'd0, leds}, 8'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
